// File: rtl/ksw_pkg.sv
// Shared constants for the ksw anti-diagonal update datapath.
package ksw_pkg;

  // Default signed H width and its most negative value (used as "minus infinity").
  localparam int unsigned KswHW = 32;
  localparam logic [KswHW-1:0] KswNegInf = {1'b1, {(KswHW-1){1'b0}}};

  // Diagonal sequencer states.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHead  = 2'd1;
  localparam logic [1:0] StBody  = 2'd2;
  localparam logic [1:0] StFinal = 2'd3;

endpackage

// File: rtl/ksw_lane_argmax.sv
// Combinational masked argmax across LANES values; ties resolve to the lowest lane.
module ksw_lane_argmax #(
  parameter int unsigned LANES = 4,
  parameter int unsigned H_W   = 32,
  localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][H_W-1:0] i_val,
  input  logic [LANES-1:0]          i_mask,
  output logic [H_W-1:0]            o_max,
  output logic [LW-1:0]             o_lane,
  output logic                      o_any
);

  logic [H_W-1:0] w_max;
  logic [LW-1:0]  w_lane;
  logic           w_any;

  // Ascending scan with a strict compare, so an equal later lane never displaces an earlier one.
  always_comb begin
    w_max  = '0;
    w_lane = '0;
    w_any  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (i_mask[k] && (!w_any || ($signed(i_val[k]) > $signed(w_max)))) begin
        w_max  = i_val[k];
        w_lane = LW'(k);
        w_any  = 1'b1;
      end
    end
  end

  assign o_max  = w_max;
  assign o_lane = w_lane;
  assign o_any  = w_any;

endmodule

// File: rtl/ksw_diag_update.sv
// Lane-parallel anti-diagonal H update with running max and end-to-end tracker update.
module ksw_diag_update
  import ksw_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned H_W   = KswHW,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned IDX_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic [H_W-1:0]     i_h0,
  input  logic               i_start_valid,
  output logic               o_start_ready,
  input  logic [IDX_W-1:0]   i_r,
  input  logic [IDX_W-1:0]   i_st,
  input  logic [IDX_W-1:0]   i_en,
  input  logic [IDX_W-1:0]   i_tlen,
  input  logic [IDX_W-1:0]   i_qlen,
  input  logic [7:0]         i_u_en,
  input  logic [7:0]         i_v_en,
  input  logic               i_v_valid,
  output logic               o_v_ready,
  input  logic [8*LANES-1:0] i_v_data,
  output logic               o_done,
  output logic               o_err,
  output logic [H_W-1:0]     o_max_h,
  output logic [IDX_W-1:0]   o_max_t,
  output logic [H_W-1:0]     o_mte,
  output logic [IDX_W-1:0]   o_mte_q,
  output logic [H_W-1:0]     o_mqe,
  output logic [IDX_W-1:0]   o_mqe_t,
  output logic [H_W-1:0]     o_score
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [H_W-1:0] NegInf = {1'b1, {(H_W-1){1'b0}}};

  logic [H_W-1:0]   r_h [DEPTH];
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_r, r_st, r_en, r_tlen, r_qlen, r_t0, r_run_t;
  logic [IDX_W-1:0] r_max_t, r_mte_q, r_mqe_t;
  logic [7:0]       r_u_en, r_v_en;
  logic             r_err;
  logic [H_W-1:0]   r_run_h, r_hen, r_hst, r_max_h, r_mte, r_mqe, r_score;

  logic                      w_start, w_illegal, w_beat, w_last, w_upd, w_to_final;
  logic [IDX_W-1:0]          w_en_m1, w_fin_t;
  logic [H_W-1:0]            w_hen, w_hen_cur, w_hst_cur, w_fin_h;
  logic [IDX_W-1:0]          w_t [LANES];
  logic [AW-1:0]             w_idx [LANES];
  logic [LANES-1:0][H_W-1:0] w_new;
  logic [LANES-1:0]          w_mask;
  logic [H_W-1:0]            w_bmax;
  logic [LW-1:0]             w_blane;
  logic                      w_bany;

  function automatic logic [H_W-1:0] sext8(input logic [7:0] x);
    return {{(H_W-8){x[7]}}, x};
  endfunction

  assign o_start_ready = (r_state == StIdle) && !i_clear;
  assign o_v_ready     = (r_state == StBody);
  assign o_done        = (r_state == StFinal);
  assign o_err         = o_done && r_err;
  assign o_max_h       = r_max_h;
  assign o_max_t       = r_max_t;
  assign o_mte         = r_mte;
  assign o_mte_q       = r_mte_q;
  assign o_mqe         = r_mqe;
  assign o_mqe_t       = r_mqe_t;
  assign o_score       = r_score;

  assign w_start   = i_start_valid && o_start_ready;
  assign w_illegal = (i_st > i_en) || (i_en >= i_tlen) || (32'(i_tlen) > 32'(DEPTH));
  assign w_beat    = (r_state == StBody) && i_v_valid;
  assign w_last    = ({1'b0, r_t0} + (IDX_W+1)'(LANES)) >= {1'b0, r_en};

  // New H[en]: from the left neighbour when one exists, else from the cell itself.
  always_comb begin
    w_en_m1 = r_en - IDX_W'(1);
    if (r_en != '0) begin
      w_hen = r_h[AW'(w_en_m1)] + sext8(r_u_en);
    end else begin
      w_hen = r_h[AW'(r_en)] + sext8(r_v_en);
    end
  end

  // Per-lane read-modify-write candidates for the current beat; lanes at or past en are masked.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_t[k]    = r_t0 + IDX_W'(k);
      w_idx[k]  = AW'(w_t[k]);
      w_mask[k] = (w_t[k] < r_en);
      w_new[k]  = r_h[w_idx[k]] + sext8(i_v_data[8*k +: 8]);
    end
  end

  ksw_lane_argmax #(
    .LANES (LANES),
    .H_W   (H_W)
  ) u_argmax (
    .i_val  (w_new),
    .i_mask (w_mask),
    .o_max  (w_bmax),
    .o_lane (w_blane),
    .o_any  (w_bany)
  );

  // Final values as they stand on the cycle that hands over to FINAL.
  always_comb begin
    w_upd      = w_bany && ($signed(w_bmax) > $signed(r_run_h));
    w_hen_cur  = (r_state == StHead) ? w_hen : r_hen;
    w_hst_cur  = r_hst;
    w_fin_h    = r_run_h;
    w_fin_t    = r_run_t;
    w_to_final = 1'b0;
    if (r_state == StHead) begin
      w_hst_cur  = w_hen;
      w_fin_h    = w_hen;
      w_fin_t    = r_en;
      w_to_final = (r_en == r_st);
    end else if (w_beat) begin
      if (r_t0 == r_st) w_hst_cur = w_new[0];
      if (w_upd) begin
        w_fin_h = w_bmax;
        w_fin_t = r_t0 + IDX_W'(w_blane);
      end
      w_to_final = w_last;
    end
  end

  // Sequencer, running max and the tracker/result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_r     <= '0;
      r_st    <= '0;
      r_en    <= '0;
      r_tlen  <= '0;
      r_qlen  <= '0;
      r_t0    <= '0;
      r_u_en  <= '0;
      r_v_en  <= '0;
      r_err   <= 1'b0;
      r_run_h <= '0;
      r_run_t <= '0;
      r_hen   <= '0;
      r_hst   <= '0;
      r_max_h <= '0;
      r_max_t <= '0;
      r_mte   <= NegInf;
      r_mte_q <= '0;
      r_mqe   <= NegInf;
      r_mqe_t <= '0;
      r_score <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_clear) begin
            r_mte   <= NegInf;
            r_mqe   <= NegInf;
            r_score <= '0;
          end else if (w_start) begin
            r_r     <= i_r;
            r_st    <= i_st;
            r_en    <= i_en;
            r_tlen  <= i_tlen;
            r_qlen  <= i_qlen;
            r_u_en  <= i_u_en;
            r_v_en  <= i_v_en;
            r_t0    <= i_st;
            r_err   <= w_illegal;
            r_state <= w_illegal ? StFinal : StHead;
          end
        end
        StHead: begin
          r_hen   <= w_hen;
          r_run_h <= w_hen;
          r_run_t <= r_en;
          r_state <= (r_en == r_st) ? StFinal : StBody;
        end
        StBody: begin
          if (w_beat) begin
            if (r_t0 == r_st) r_hst <= w_new[0];
            if (w_upd) begin
              r_run_h <= w_bmax;
              r_run_t <= r_t0 + IDX_W'(w_blane);
            end
            r_t0 <= r_t0 + IDX_W'(LANES);
            if (w_last) r_state <= StFinal;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_to_final) begin
        r_max_h <= w_fin_h;
        r_max_t <= w_fin_t;
        if ((r_en == r_tlen - IDX_W'(1)) && ($signed(w_hen_cur) > $signed(r_mte))) begin
          r_mte   <= w_hen_cur;
          r_mte_q <= r_r - r_en;
        end
        if ((r_r - r_st == r_qlen - IDX_W'(1)) && ($signed(w_hst_cur) > $signed(r_mqe))) begin
          r_mqe   <= w_hst_cur;
          r_mqe_t <= r_st;
        end
        // With en == tlen-1 the last-column cell is H[en].
        if ((r_r == r_qlen + r_tlen - IDX_W'(2)) && (r_en == r_tlen - IDX_W'(1))) begin
          r_score <= w_hen_cur;
        end
      end
    end
  end

  // H row storage: not reset, so partial writes survive a mid-diagonal reset.
  always_ff @(posedge i_clk) begin
    if ((r_state == StIdle) && i_clear) r_h[0] <= i_h0;
    if (r_state == StHead) r_h[AW'(r_en)] <= w_hen;
    if (w_beat) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_mask[k]) r_h[w_idx[k]] <= w_new[k];
      end
    end
  end

endmodule
